// File: rtl/gpsdo_pkg.sv
// Shared GPSDO definitions: UART byte width, TX FSM state codes and the
// status byte codes exchanged between the 1PPS comparator and the UART stage.
package gpsdo_pkg;

  localparam int UART_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [UART_W-1:0] ST_HOLD     = 8'd0;
  localparam logic [UART_W-1:0] ST_GPS_LEAD = 8'd1;
  localparam logic [UART_W-1:0] ST_LOC_LEAD = 8'd2;
  localparam logic [UART_W-1:0] ST_TIMEOUT  = 8'd9;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; binary pointers with one extra
// wrap bit distinguish full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK_SYS,
  input  logic             CLK_RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_wr = push & (~full | pop);
  assign do_rd = pop & ~empty;

  always_ff @(posedge CLK_SYS) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers comparator status bytes (one per rising edge of Uart_En) and sends
// them as 8N1 UART frames; counts bytes dropped on overflow.
module uart_tx_fifo
  import gpsdo_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter int OVF_W      = 16
) (
  input  logic                         CLK_SYS,
  input  logic                         CLK_RST,
  input  logic                         Uart_En,
  input  logic [UART_W-1:0]            Uart_Data,
  output logic                         Uart_Busy,
  output logic                         UART_TX,
  output logic [$clog2(FIFO_DEPTH):0]  Fifo_Level,
  output logic [OVF_W-1:0]             Ovf_Cnt,
  output logic [1:0]                   dbg_state
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_t         state;
  logic [CW-1:0]     baud_cnt;
  logic [2:0]        bit_idx;
  logic [UART_W-1:0] shreg;
  logic              en_d;
  logic              push;
  logic              pop;
  logic              drop;
  logic              bit_end;
  logic              fifo_full;
  logic              fifo_empty;
  logic [UART_W-1:0] fifo_dout;

  assign dbg_state = state;
  assign push      = Uart_En & ~en_d;
  assign bit_end   = (baud_cnt == CW'(DIV - 1));
  // Head leaves the FIFO when the line is free: from IDLE, or at the last STOP cycle.
  assign pop       = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign drop      = push & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (UART_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK_SYS (CLK_SYS),
    .CLK_RST (CLK_RST),
    .push    (push),
    .pop     (pop),
    .din     (Uart_Data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (Fifo_Level)
  );

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      en_d    <= 1'b0;
      Ovf_Cnt <= '0;
    end else begin
      en_d <= Uart_En;
      if (drop && (Ovf_Cnt != '1)) Ovf_Cnt <= Ovf_Cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      UART_TX   <= 1'b1;
      Uart_Busy <= 1'b0;
    end else begin
      Uart_Busy <= (state != IDLE) | ~fifo_empty;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            state   <= START;
            shreg   <= fifo_dout;
            UART_TX <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            UART_TX  <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              UART_TX <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              UART_TX <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            // Back-to-back frames: next start bit follows the stop bit directly.
            if (pop) begin
              state   <= START;
              shreg   <= fifo_dout;
              UART_TX <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          UART_TX  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: every cycle the line, busy, level, overflow count and
// idle state are compared with a frame-schedule model built from the byte pushes.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DIV      = 10;
  localparam int FRAME    = 10 * DIV;
  localparam int DEPTH    = 8;
  localparam int OVF_W    = 3;
  localparam int OVF_MAX  = (1 << OVF_W) - 1;

  logic        CLK_SYS;
  logic        CLK_RST;
  logic        Uart_En;
  logic [7:0]  Uart_Data;
  logic        Uart_Busy;
  logic        UART_TX;
  logic [3:0]  Fifo_Level;
  logic [OVF_W-1:0] Ovf_Cnt;
  logic [1:0]  dbg_state;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH),
    .OVF_W      (OVF_W)
  ) dut (
    .CLK_SYS    (CLK_SYS),
    .CLK_RST    (CLK_RST),
    .Uart_En    (Uart_En),
    .Uart_Data  (Uart_Data),
    .Uart_Busy  (Uart_Busy),
    .UART_TX    (UART_TX),
    .Fifo_Level (Fifo_Level),
    .Ovf_Cnt    (Ovf_Cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset / cycle index
  int cyc = 0;
  initial CLK_SYS = 1'b0;
  always #5 CLK_SYS = ~CLK_SYS;
  always @(posedge CLK_SYS) cyc = cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  bit en_prev  = 1'b0;
  int lvl_peak = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Model: each accepted byte has a write edge and a frame start (pop) edge.
  int         w_q[$];
  int         p_q[$];
  logic [7:0] d_q[$];
  int         drop_q[$];

  function automatic void model_push(input int c, input logic [7:0] d);
    int pending = 0;
    int p;
    foreach (p_q[i]) if (p_q[i] > c) pending++;
    if (pending < DEPTH) begin
      p = c + 1;
      if (p_q.size() > 0 && p_q[$] + FRAME > p) p = p_q[$] + FRAME;
      w_q.push_back(c);
      p_q.push_back(p);
      d_q.push_back(d);
    end else begin
      drop_q.push_back(c);
    end
  endfunction

  function automatic logic exp_tx(input int t);
    int idx;
    logic [7:0] b;
    foreach (p_q[i]) begin
      if (t >= p_q[i] && t < p_q[i] + FRAME) begin
        idx = (t - p_q[i]) / DIV;
        b   = d_q[i];
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_active(input int t);
    foreach (p_q[i]) if (t >= p_q[i] && t < p_q[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_level(input int t);
    int n = 0;
    foreach (p_q[i]) if (w_q[i] <= t && t < p_q[i]) n++;
    return n;
  endfunction

  function automatic logic exp_busy(input int t);
    foreach (p_q[i]) if (w_q[i] <= t - 1 && t - 1 < p_q[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_ovf(input int t);
    int n = 0;
    foreach (drop_q[i]) if (drop_q[i] <= t) n++;
    return (n > OVF_MAX) ? OVF_MAX : n;
  endfunction

  // scoreboard: every cycle, away from the active edge
  always @(negedge CLK_SYS) begin
    if (chk_en) begin
      chk("tx",    {31'd0, UART_TX},   {31'd0, exp_tx(cyc)});
      chk("busy",  {31'd0, Uart_Busy}, {31'd0, exp_busy(cyc)});
      chk("level", {28'd0, Fifo_Level}, exp_level(cyc));
      chk("ovf",   {29'd0, Ovf_Cnt},   exp_ovf(cyc));
      chk("idle",  {31'd0, (dbg_state == 2'd0)}, {31'd0, ~exp_active(cyc)});
      if (int'(Fifo_Level) > lvl_peak) lvl_peak = int'(Fifo_Level);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK_SYS);
      #1;
    end
  endtask

  task automatic set_en(input logic v, input logic [7:0] d);
    Uart_Data = d;
    Uart_En   = v;
    if (v && !en_prev) model_push(cyc + 1, d);
    en_prev = v;
  endtask

  task automatic pulse(input logic [7:0] d, input int gap);
    set_en(1'b1, d);
    step(1);
    set_en(1'b0, d);
    step(gap - 1);
  endtask

  function automatic void model_clear();
    w_q.delete();
    p_q.delete();
    d_q.delete();
    drop_q.delete();
  endfunction

  initial begin
    int idx0;
    int target;
    CLK_RST   = 1'b0;
    Uart_En   = 1'b0;
    Uart_Data = 8'h00;
    step(3);
    chk("rst_tx",   {31'd0, UART_TX}, 32'd1);
    chk("rst_busy", {31'd0, Uart_Busy}, 32'd0);
    CLK_RST = 1'b1;
    chk_en  = 1'b1;

    // 1: quiet line after reset
    step(200);
    chk("t1_tx",    {31'd0, UART_TX}, 32'd1);
    chk("t1_busy",  {31'd0, Uart_Busy}, 32'd0);
    chk("t1_level", {28'd0, Fifo_Level}, 32'd0);
    chk("t1_ovf",   {29'd0, Ovf_Cnt}, 32'd0);

    // 2: long enable gives one frame of 0x02
    set_en(1'b1, 8'h02);
    step(50);
    set_en(1'b0, 8'h02);
    step(150);
    chk("t2_frames", p_q.size(), 32'd1);

    // 3: three back-to-back frames
    lvl_peak = 0;
    pulse(8'h01, 3);
    pulse(8'h09, 3);
    pulse(8'h00, 3);
    step(400);
    chk("t3_peak", lvl_peak, 32'd2);

    // 4: eleven pulses while idle, two dropped
    for (int i = 0; i <= 10; i++) pulse(8'(i), 2);
    chk("t4_level", {28'd0, Fifo_Level}, 32'd8);
    chk("t4_ovf",   {29'd0, Ovf_Cnt}, 32'd2);
    step(1000);

    // 6: push on the STOP->START pop while full is accepted
    idx0 = p_q.size();
    for (int i = 0; i < 9; i++) pulse(8'hA0 + 8'(i), 2);
    chk("t6_full", {28'd0, Fifo_Level}, 32'd8);
    target = p_q[idx0] + FRAME - 1;
    step(target - cyc);
    set_en(1'b1, 8'hB5);
    step(1);
    set_en(1'b0, 8'hB5);
    chk("t6_level", {28'd0, Fifo_Level}, 32'd8);
    chk("t6_ovf",   {29'd0, Ovf_Cnt}, 32'd2);
    step(1100);

    // overflow counter saturates at all-ones
    for (int i = 0; i < 20; i++) pulse(8'h30 + 8'(i), 2);
    chk("sat_ovf", {29'd0, Ovf_Cnt}, OVF_MAX);
    step(1000);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      pulse(8'($urandom_range(0, 255)), $urandom_range(2, 140));
    end
    step(1200);

    // 5: async reset during data bit 3
    pulse(8'h5A, 2);
    pulse(8'hC3, 2);
    target = p_q[$-1] + 4 * DIV + 3;
    step(target - cyc);
    #2;
    chk_en  = 1'b0;
    CLK_RST = 1'b0;
    #1;
    chk("t5_tx",    {31'd0, UART_TX}, 32'd1);
    chk("t5_busy",  {31'd0, Uart_Busy}, 32'd0);
    chk("t5_level", {28'd0, Fifo_Level}, 32'd0);
    chk("t5_ovf",   {29'd0, Ovf_Cnt}, 32'd0);
    step(2);
    model_clear();
    CLK_RST = 1'b1;
    chk_en  = 1'b1;
    step(200);
    chk("t5_quiet", {31'd0, Uart_Busy}, 32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
